// File: rtl/channel_noise_injector_pkg.sv
// Shared widths and the clip-to-range adder used by the noise injector.
package noise_chan_pkg;

  localparam int DEF_SIG_W   = 8;
  localparam int DEF_NOISE_W = 8;
  localparam int CNT_W       = 16;

  typedef struct packed {
    logic signed [31:0] val;
    logic               sat;
  } sat_res_t;

  // Adds two sign-extended operands and clips the sum to a signed w-bit range.
  function automatic sat_res_t sat_add(input logic signed [31:0] sig,
                                       input logic signed [31:0] noise_scaled,
                                       input int                 w);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sat_res_t           r;
    sum   = sig + noise_scaled;
    hi    = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo    = -hi - 32'sd1;
    r.sat = 1'b1;
    if (sum > hi)      r.val = hi;
    else if (sum < lo) r.val = lo;
    else begin
      r.val = sum;
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/channel_noise_injector_sync_fifo.sv
// Shallow synchronous FIFO with wrap-bit pointers and a combinational head.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  // Push into a full FIFO is only issued alongside a pop; the slot written is
  // the one being read this cycle, so the head still sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  assign head  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/channel_noise_injector.sv
// Pairs each Tx symbol with one noise sample, adds with saturation, and keeps stats.
module channel_noise_injector
  import noise_chan_pkg::*;
#(
  parameter int SIG_W       = DEF_SIG_W,
  parameter int NOISE_W     = DEF_NOISE_W,
  parameter int DEPTH       = 4,
  parameter int NOISE_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      noise_bypass,
  input  logic signed [SIG_W-1:0]   sig_in,
  input  logic                      sig_in_valid,
  output logic                      sig_in_ready,
  input  logic signed [NOISE_W-1:0] noise_in,
  input  logic                      noise_in_valid,
  output logic signed [SIG_W-1:0]   rx_out,
  output logic                      rx_out_valid,
  output logic [CNT_W-1:0]          sat_count,
  output logic [CNT_W-1:0]          drop_count
);

  logic [SIG_W-1:0]   sig_head;
  logic [NOISE_W-1:0] noise_head;
  logic               sig_full, sig_empty, noise_full, noise_empty;
  logic               sig_push, noise_push, pop, drop;

  assign pop          = en && !sig_empty && !noise_empty;
  assign sig_in_ready = !sig_full;
  assign sig_push     = sig_in_valid && !sig_full;
  // Noise has no backpressure: a full FIFO still accepts if it pops this cycle.
  assign noise_push   = noise_in_valid && (!noise_full || pop);
  assign drop         = noise_in_valid && noise_full && !pop;

  sync_fifo #(.W(SIG_W), .DEPTH(DEPTH)) u_sig_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sig_push),
    .pop   (pop),
    .din   (sig_in),
    .head  (sig_head),
    .full  (sig_full),
    .empty (sig_empty)
  );

  sync_fifo #(.W(NOISE_W), .DEPTH(DEPTH)) u_noise_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (noise_push),
    .pop   (pop),
    .din   (noise_in),
    .head  (noise_head),
    .full  (noise_full),
    .empty (noise_empty)
  );

  logic signed [NOISE_W-1:0] noise_shr;
  logic signed [31:0]        sig_ext;
  logic signed [31:0]        noise_ext;
  sat_res_t                  res;
  logic                      unused_hi;

  assign noise_shr = $signed(noise_head) >>> NOISE_SHIFT;
  assign sig_ext   = 32'($signed(sig_head));
  assign noise_ext = noise_bypass ? 32'sd0 : 32'(noise_shr);
  assign res       = sat_add(sig_ext, noise_ext, SIG_W);
  assign unused_hi = ^res.val[31:SIG_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_out       <= '0;
      rx_out_valid <= 1'b0;
      sat_count    <= '0;
      drop_count   <= '0;
    end else begin
      rx_out_valid <= pop;
      if (pop) rx_out <= res.val[SIG_W-1:0];
      if (pop && res.sat && (sat_count != '1)) sat_count <= sat_count + 1'b1;
      if (drop && (drop_count != '1))          drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_channel_noise_injector.sv
// Drives two injectors (noise shift 0 and 2) from one stimulus and checks them against a queue model.
module tb_channel_noise_injector;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              noise_bypass = 1'b0;
  logic              sig_in_valid = 1'b0;
  logic              noise_in_valid = 1'b0;
  logic signed [7:0] sig_in = '0;
  logic signed [7:0] noise_in = '0;

  logic signed [7:0] rx0, rx2;
  logic              rv0, rv2, rdy0, rdy2;
  logic [15:0]       sat0, sat2, drp0, drp2;

  always #5 clk = ~clk;

  channel_noise_injector #(.SIG_W(8), .NOISE_W(8), .DEPTH(DEPTH), .NOISE_SHIFT(0)) d0 (
    .clk(clk), .rst(rst), .en(en), .noise_bypass(noise_bypass),
    .sig_in(sig_in), .sig_in_valid(sig_in_valid), .sig_in_ready(rdy0),
    .noise_in(noise_in), .noise_in_valid(noise_in_valid),
    .rx_out(rx0), .rx_out_valid(rv0), .sat_count(sat0), .drop_count(drp0)
  );

  channel_noise_injector #(.SIG_W(8), .NOISE_W(8), .DEPTH(DEPTH), .NOISE_SHIFT(2)) d2 (
    .clk(clk), .rst(rst), .en(en), .noise_bypass(noise_bypass),
    .sig_in(sig_in), .sig_in_valid(sig_in_valid), .sig_in_ready(rdy2),
    .noise_in(noise_in), .noise_in_valid(noise_in_valid),
    .rx_out(rx2), .rx_out_valid(rv2), .sat_count(sat2), .drop_count(drp2)
  );

  int checks = 0;
  int errors = 0;

  int sq[$];
  int nq[$];
  int src[$];
  int exp_out[2];
  int sat_m[2];
  int exp_vld;
  int drop_m;

  function automatic int clip(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("rx_valid_s0", 32'(rv0), exp_vld);
    chk("rx_out_s0", 32'(rx0), exp_out[0]);
    chk("rx_valid_s2", 32'(rv2), exp_vld);
    chk("rx_out_s2", 32'(rx2), exp_out[1]);
    chk("ready_s0", 32'(rdy0), (sq.size() < DEPTH) ? 1 : 0);
    chk("ready_s2", 32'(rdy2), (sq.size() < DEPTH) ? 1 : 0);
    chk("sat_s0", 32'(sat0), sat_m[0]);
    chk("sat_s2", 32'(sat2), sat_m[1]);
    chk("drop_s0", 32'(drp0), drop_m);
    chk("drop_s2", 32'(drp2), drop_m);
  endtask

  task automatic model_reset();
    sq.delete();
    nq.delete();
    exp_out = '{0, 0};
    sat_m   = '{0, 0};
    exp_vld = 0;
    drop_m  = 0;
  endtask

  // One clock of stimulus; the model applies the cycle's rules to its queues.
  task automatic step(input bit sv, input bit nv, input int nval, input bit e, input bit b);
    bit acc, popm;
    int s, n, ns, v;
    sig_in_valid   = sv && (src.size() > 0);
    sig_in         = sig_in_valid ? 8'(src[0]) : 8'sd0;
    noise_in_valid = nv;
    noise_in       = 8'(nval);
    en             = e;
    noise_bypass   = b;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      acc  = sig_in_valid && (sq.size() < DEPTH);
      popm = e && (sq.size() > 0) && (nq.size() > 0);
      exp_vld = popm ? 1 : 0;
      if (popm) begin
        s = sq.pop_front();
        n = nq.pop_front();
        for (int k = 0; k < 2; k++) begin
          ns = b ? 0 : (n >>> (k * 2));
          v  = s + ns;
          exp_out[k] = clip(v);
          if (v != exp_out[k] && sat_m[k] < 65535) sat_m[k]++;
        end
      end
      if (acc) sq.push_back(src.pop_front());
      if (nv) begin
        if (nq.size() < DEPTH) nq.push_back(nval);
        else if (drop_m < 65535) drop_m++;
      end
    end
    #1 check_all();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all();
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);

    // basic add
    src = '{64, -64, 10};
    step(1, 1, 3, 1, 0);
    chk("basic_lat0", 32'(rv0), 0);
    step(1, 1, -5, 1, 0);
    chk("basic_lat1", 32'(rv0), 1);
    chk("basic0", 32'(rx0), 67);
    step(1, 1, 0, 1, 0);
    chk("basic1", 32'(rx0), -69);
    step(0, 0, 0, 1, 0);
    chk("basic2", 32'(rx0), 10);
    step(0, 0, 0, 1, 0);
    chk("idle_vld", 32'(rv0), 0);
    chk("hold", 32'(rx0), 10);

    // saturation, then the same with bypass
    src = '{120, -120};
    step(1, 1, 20, 1, 0);
    step(1, 1, -20, 1, 0);
    chk("sat_hi", 32'(rx0), 127);
    step(0, 0, 0, 1, 0);
    chk("sat_lo", 32'(rx0), -128);
    chk("sat_cnt", 32'(sat0), 2);
    src = '{120, -120};
    step(1, 1, 20, 1, 1);
    step(1, 1, -20, 1, 1);
    chk("byp_hi", 32'(rx0), 120);
    step(0, 0, 0, 1, 1);
    chk("byp_lo", 32'(rx0), -120);
    chk("byp_sat_cnt", 32'(sat0), 2);

    // arithmetic shift of noise
    src = '{0, 0};
    step(1, 1, -7, 1, 0);
    step(1, 1, 7, 1, 0);
    chk("shift_neg", 32'(rx2), -2);
    step(0, 0, 0, 1, 0);
    chk("shift_pos", 32'(rx2), 1);

    // backpressure and drops with en low
    src = '{11, 12, 13, 14, 15, 16};
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 30 + k, 0, 0);
      if (k == 3) chk("ready_fall", 32'(rdy0), 0);
    end
    chk("drop_cnt", 32'(drp0), 2);
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 0, 1, 0);
      chk("drain_pair", 32'(rx0), 41 + 2 * j);
    end
    step(0, 0, 0, 1, 0);
    chk("drain_done", 32'(rv0), 0);
    src.delete();

    // mid-run reset with both FIFOs half full
    src = '{1, 2, 3};
    step(1, 1, 10, 0, 0);
    step(1, 1, 20, 0, 0);
    step(1, 1, 30, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("pre_rst_vld", 32'(rv0), 1);
    rst = 1'b1;
    #1;
    model_reset();
    src.delete();
    check_all();
    chk("rst_async_out", 32'(rx0), 0);
    step(0, 0, 0, 1, 0);
    rst = 1'b0;
    src = '{5};
    step(1, 1, 7, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("post_rst_pair", 32'(rx0), 12);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (src.size() < 2) src.push_back(int'($urandom_range(0, 255)) - 128);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
